param_updown_counter: RTL and testbench

//   Parametrised synchronous up/down counter built from the team's 8-bit enable counter.

---
 rtl/param_updown_counter.sv | 75 +++++++
 tb/tb_param_updown_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with modulus, load, clear and wrap/saturate
`timescale 1ns/1ps

module param_updown_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             Clock,
    input  logic             Clear_b,
    input  logic             SyncClear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Enable,
    input  logic             Up,
    output logic [WIDTH-1:0] CounterValue,
    output logic             AtMax,
    output logic             AtZero,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    // Loads above the modulus are pinned to the top count so the range invariant holds.
    always_comb begin
        load_clamped = (LoadValue > MAX_VALUE) ? MAX_VALUE : LoadValue;
    end

    // Next count and wrap pulse; priority is clear, then load, then enabled count, else hold.
    always_comb begin
        count_next = CounterValue;
        wrap_next  = 1'b0;
        if (SyncClear) begin
            count_next = ZERO;
        end else if (Load) begin
            count_next = load_clamped;
        end else if (Enable) begin
            if (Up) begin
                if (CounterValue < MAX_VALUE) begin
                    count_next = CounterValue + ONE;
                end else if (!SATURATE) begin
                    count_next = ZERO;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (CounterValue != ZERO) begin
                    count_next = CounterValue - ONE;
                end else if (!SATURATE) begin
                    count_next = MAX_VALUE;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    // Count and wrap registers; Clear_b discards everything immediately.
    always_ff @(posedge Clock or negedge Clear_b) begin
        if (!Clear_b) begin
            CounterValue <= ZERO;
            Wrap         <= 1'b0;
        end else begin
            CounterValue <= count_next;
            Wrap         <= wrap_next;
        end
    end

    assign AtMax  = (CounterValue == MAX_VALUE);
    assign AtZero = (CounterValue == ZERO);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - scoreboard bench driving six counter configurations in lockstep
`timescale 1ns/1ps

module tb_param_updown_counter;

    localparam int N = 6;

    logic        Clock = 1'b0;
    logic        Clear_b = 1'b0;
    logic        SyncClear = 1'b0;
    logic        Load = 1'b0;
    logic [31:0] LoadValue = '0;
    logic        Enable = 1'b0;
    logic        Up = 1'b0;

    logic [7:0]  cv0;
    logic [3:0]  cv1, cv2, cv3;
    logic [1:0]  cv4;
    logic [31:0] cv5;
    logic [N-1:0] atmax, atzero, wrap;
    logic [31:0] dv [N];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0]       w;
        logic [N-1:0][31:0] v;
    } exp_t;

    exp_t q [$];
    longint unsigned mval [N];

    always #5 Clock = ~Clock;

    // 0: defaults (W8, max 255, wrap)  1: W4 max 9 wrap  2: W4 max 9 saturate
    // 3: W4 max 12 wrap                4: W2 max 1 wrap  5: W32 full range saturate
    param_updown_counter u0 (.Clock(Clock), .Clear_b(Clear_b), .SyncClear(SyncClear), .Load(Load),
        .LoadValue(LoadValue[7:0]), .Enable(Enable), .Up(Up), .CounterValue(cv0),
        .AtMax(atmax[0]), .AtZero(atzero[0]), .Wrap(wrap[0]));
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0)) u1 (.Clock(Clock),
        .Clear_b(Clear_b), .SyncClear(SyncClear), .Load(Load), .LoadValue(LoadValue[3:0]),
        .Enable(Enable), .Up(Up), .CounterValue(cv1), .AtMax(atmax[1]), .AtZero(atzero[1]), .Wrap(wrap[1]));
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b1)) u2 (.Clock(Clock),
        .Clear_b(Clear_b), .SyncClear(SyncClear), .Load(Load), .LoadValue(LoadValue[3:0]),
        .Enable(Enable), .Up(Up), .CounterValue(cv2), .AtMax(atmax[2]), .AtZero(atzero[2]), .Wrap(wrap[2]));
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(4'd12), .SATURATE(1'b0)) u3 (.Clock(Clock),
        .Clear_b(Clear_b), .SyncClear(SyncClear), .Load(Load), .LoadValue(LoadValue[3:0]),
        .Enable(Enable), .Up(Up), .CounterValue(cv3), .AtMax(atmax[3]), .AtZero(atzero[3]), .Wrap(wrap[3]));
    param_updown_counter #(.WIDTH(2), .MAX_VALUE(2'd1), .SATURATE(1'b0)) u4 (.Clock(Clock),
        .Clear_b(Clear_b), .SyncClear(SyncClear), .Load(Load), .LoadValue(LoadValue[1:0]),
        .Enable(Enable), .Up(Up), .CounterValue(cv4), .AtMax(atmax[4]), .AtZero(atzero[4]), .Wrap(wrap[4]));
    param_updown_counter #(.WIDTH(32), .SATURATE(1'b1)) u5 (.Clock(Clock),
        .Clear_b(Clear_b), .SyncClear(SyncClear), .Load(Load), .LoadValue(LoadValue),
        .Enable(Enable), .Up(Up), .CounterValue(cv5), .AtMax(atmax[5]), .AtZero(atzero[5]), .Wrap(wrap[5]));

    assign dv[0] = {24'b0, cv0};
    assign dv[1] = {28'b0, cv1};
    assign dv[2] = {28'b0, cv2};
    assign dv[3] = {28'b0, cv3};
    assign dv[4] = {30'b0, cv4};
    assign dv[5] = cv5;

    function automatic longint unsigned cfg_max(input int i);
        case (i)
            0:       return 64'd255;
            1, 2:    return 64'd9;
            3:       return 64'd12;
            4:       return 64'd1;
            default: return 64'hFFFF_FFFF;
        endcase
    endfunction

    function automatic longint unsigned cfg_mask(input int i);
        case (i)
            0:       return 64'hFF;
            1, 2, 3: return 64'hF;
            4:       return 64'h3;
            default: return 64'hFFFF_FFFF;
        endcase
    endfunction

    function automatic bit cfg_sat(input int i);
        return (i == 2) || (i == 5);
    endfunction

    task automatic chk(input string name, input int i, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, i, act, req, $time);
        end
    endtask

    // One cycle of stimulus: drive between edges, predict the effect of the coming edge.
    task automatic step(input bit rn, input bit sc, input bit ld, input logic [31:0] lv,
                        input bit en, input bit up);
        exp_t e;
        longint unsigned mx, nv, lvi;
        bit w;
        @(negedge Clock);
        #1;
        Clear_b = rn; SyncClear = sc; Load = ld; LoadValue = lv; Enable = en; Up = up;
        for (int i = 0; i < N; i++) begin
            mx  = cfg_max(i);
            lvi = longint'(lv) & cfg_mask(i);
            nv  = mval[i];
            w   = 1'b0;
            if (!rn)     nv = 0;
            else if (sc) nv = 0;
            else if (ld) nv = (lvi > mx) ? mx : lvi;
            else if (en && up) begin
                if (mval[i] < mx) nv = mval[i] + 1;
                else if (!cfg_sat(i)) begin nv = 0; w = 1'b1; end
            end else if (en) begin
                if (mval[i] > 0) nv = mval[i] - 1;
                else if (!cfg_sat(i)) begin nv = mx; w = 1'b1; end
            end
            mval[i] = nv;
            e.v[i]  = nv[31:0];
            e.w[i]  = w;
        end
        q.push_back(e);
        if (!rn) begin
            #1;
            for (int i = 0; i < N; i++) begin
                chk("async_clear_value", i, longint'(dv[i]), 0);
                chk("async_clear_wrap", i, longint'(wrap[i]), 0);
                chk("async_clear_atzero", i, longint'(atzero[i]), 1);
            end
        end
    endtask

    // Monitor: every falling edge compares the DUT state against the oldest prediction.
    always @(negedge Clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < N; i++) begin
                chk("value", i, longint'(dv[i]), longint'(e.v[i]));
                chk("wrap", i, longint'(wrap[i]), longint'(e.w[i]));
                chk("atmax", i, longint'(atmax[i]), (longint'(e.v[i]) == cfg_max(i)) ? 1 : 0);
                chk("atzero", i, longint'(atzero[i]), (e.v[i] == 32'd0) ? 1 : 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit rn, sc, ld, en, up;
        logic [31:0] lv;
        for (int i = 0; i < N; i++) mval[i] = 0;

        // Full-range count up from reset, through the 255->0 wrap.
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 258; k++) step(1, 0, 0, 0, 1, 1);

        // Count down from reset: modulus-10 counters wrap to 9 then descend.
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) step(1, 0, 0, 0, 1, 0);

        // Load 7 then count up into the top.
        step(1, 0, 1, 32'd7, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 1, 1);

        // Over-range load with Enable, then clear and load together.
        step(1, 0, 1, 32'hFFFF_FFFF, 1, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 1, 32'd5, 1, 1);
        step(1, 0, 0, 0, 0, 0);

        // Count to 0x5A, drop reset between edges, resume.
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 90; k++) step(1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, 1);

        // Enable every other cycle with the direction alternating.
        for (int k = 0; k < 24; k++) step(1, 0, 0, 0, k[0], k[1]);

        // Randomised traffic.
        for (int k = 0; k < 2000; k++) begin
            rn = ($urandom_range(63) != 0);
            sc = ($urandom_range(15) == 0);
            ld = ($urandom_range(7) == 0);
            lv = ($urandom_range(1) == 1) ? 32'($urandom_range(15)) : $urandom;
            en = ($urandom_range(3) != 0);
            up = 1'($urandom_range(1));
            step(rn, sc, ld, lv, en, up);
        end

        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge Clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
